// File: rtl/i2s_input.sv
// I2S capture receiver: oversamples BCK/LCK/DIN on clk and delivers left/right pairs on a valid/ack handshake.
// Optional short-slot detection is enabled by defining I2S_INPUT_FRAME_CHECK_EN.
`timescale 1ns/1ps
module i2s_input #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             sys_rst_i,
  input  logic             i2s_bck,
  input  logic             i2s_lrck,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] left_o,
  output logic [WIDTH-1:0] right_o,
  output logic             valid_o,
  input  logic             ack_i,
  output logic             overrun_o,
  output logic             frame_err_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {HUNT, SHIFT, WAIT} state_t;

  // Bit order on pin_in / sync_bits: 0 = BCK, 1 = LCK, 2 = DIN.
  logic [2:0] pin_in;
  logic [2:0] sync_bits;

  assign pin_in = {i2s_din, i2s_lrck, i2s_bck};

  // Identical two-stage synchronizers keep the three lines mutually aligned.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (sys_rst_i) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= pin_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic bck_s, lrck_s, din_s;
  assign bck_s  = sync_bits[0];
  assign lrck_s = sync_bits[1];
  assign din_s  = sync_bits[2];

  logic             bck_d_reg;
  logic             lrck_prev_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic             chan_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] left_hold_reg;
  logic             have_left_reg;
  logic [WIDTH-1:0] left_reg;
  logic [WIDTH-1:0] right_reg;
  logic             valid_reg;
  logic             overrun_reg;

  logic             bck_rise;
  logic             boundary;
  logic             word_done;
  logic             pair_load;
  logic [WIDTH-1:0] word_next;

  assign bck_rise  = bck_s & ~bck_d_reg;
  assign boundary  = bck_rise & (lrck_s != lrck_prev_reg);
  assign word_next = {shift_reg[WIDTH-2:0], din_s};
  // The WIDTH-th bit completes the word in the same cycle it is shifted in.
  assign word_done = bck_rise & ~boundary & (state_reg == SHIFT) &
                     (bit_cnt_reg == CNT_W'(WIDTH - 1));
  assign pair_load = word_done & chan_reg & have_left_reg;

  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      bck_d_reg     <= 1'b0;
      lrck_prev_reg <= 1'b0;
      state_reg     <= HUNT;
      bit_cnt_reg   <= '0;
      chan_reg      <= 1'b0;
      shift_reg     <= '0;
      left_hold_reg <= '0;
      have_left_reg <= 1'b0;
      left_reg      <= '0;
      right_reg     <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      bck_d_reg <= bck_s;
      if (bck_rise) begin
        lrck_prev_reg <= lrck_s;
      end

      // The boundary-edge DIN bit belongs to the previous slot and is never shifted.
      if (boundary) begin
        state_reg   <= SHIFT;
        bit_cnt_reg <= '0;
        chan_reg    <= lrck_s;
      end else if (bck_rise && state_reg == SHIFT) begin
        shift_reg <= word_next;
        if (word_done) begin
          state_reg   <= WAIT;
          bit_cnt_reg <= CNT_W'(WIDTH);
          if (!chan_reg) begin
            left_hold_reg <= word_next;
            have_left_reg <= 1'b1;
          end else if (have_left_reg) begin
            have_left_reg <= 1'b0;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end

      if (pair_load) begin
        left_reg  <= left_hold_reg;
        right_reg <= word_next;
        valid_reg <= 1'b1;
        if (valid_reg && !ack_i) begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && ack_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef I2S_INPUT_FRAME_CHECK_EN
  logic frame_err_reg;

  // A boundary while still shifting means the slot was shorter than WIDTH.
  always_ff @(posedge clk) begin
    if (sys_rst_i) begin
      frame_err_reg <= 1'b0;
    end else if (boundary && state_reg == SHIFT) begin
      frame_err_reg <= 1'b1;
    end
  end

  assign frame_err_o = frame_err_reg;
`else
  assign frame_err_o = 1'b0;
`endif

  assign left_o    = left_reg;
  assign right_o   = right_reg;
  assign valid_o   = valid_reg;
  assign overrun_o = overrun_reg;

endmodule

// File: doc/i2s_input.md
# i2s_input

I2S receiver for a PMOD-mounted stereo ADC, the capture-side counterpart of the design's I2S DAC output path. The external ADC is clock master: it drives BCK, LCK and DIN. This block oversamples those three lines with the 6 MHz system clock. It deserializes standard I2S frames (MSB first, one-BCK delay after each LCK edge, LCK low = left) into 16-bit two's-complement left/right sample pairs. Each pair is presented on a valid/ack handshake to downstream audio logic.

## Interface
- `WIDTH`, default 16: bits captured per channel word.
- `clk`  in  1  system clock, 6 MHz.
- `sys_rst_i`  in  1  reset, synchronous, active-high.
- `i2s_bck`  in  1  bit clock from ADC; asynchronous to `clk`; at most `clk`/4.
- `i2s_lrck`  in  1  word select from ADC; asynchronous; 0 = left, 1 = right.
- `i2s_din`  in  1  serial data from ADC; asynchronous.
- `left_o`  out  WIDTH  last complete left sample, two's complement.
- `right_o`  out  WIDTH  last complete right sample, two's complement.
- `valid_o`  out  1  a new pair is held on `left_o`/`right_o`; level, held until acked.
- `ack_i`  in  1  consumer accepts the pair; effective only while `valid_o`=1.
- `overrun_o`  out  1  sticky; a pair was overwritten before being acked.
- `frame_err_o`  out  1  sticky short-slot flag (see Configuration).

## Operation
- Input conditioning:
  - Each of `i2s_bck`, `i2s_lrck` and `i2s_din` passes through an identical 2-FF synchronizer, so the three lines stay mutually aligned.
  - A 3rd BCK stage provides rising-edge detect, `bck_rise`.
  - All remaining logic advances only on cycles where `bck_rise`=1.
- Boundary detect: at each `bck_rise`, compare the synchronized LCK with the LCK value registered at the previous `bck_rise`. A difference marks a boundary edge.
- FSM states:
  - HUNT (reset state): ignore data. On a boundary edge, go to SHIFT, clear `bit_cnt`, record channel = new LCK.
  - SHIFT: on each non-boundary `bck_rise`, shift DIN into the LSB of the shift register and increment `bit_cnt`. When `bit_cnt` reaches WIDTH, store the word and go to WAIT. On a boundary edge before WIDTH bits, discard the partial word, set the frame error if enabled, then restart SHIFT for the new channel.
  - WAIT: ignore DIN, so slot bits beyond WIDTH are dropped. On a boundary edge, go to SHIFT for the new channel.
- DIN on the boundary edge itself is never captured; it is the previous slot's trailing bit.
- Word store:
  - A left word loads the left holding register and sets `have_left`.
  - A right word with `have_left`=1 forms a pair and clears `have_left`.
  - A right word with `have_left`=0 is discarded; this is the startup-mid-frame case.
- Pair delivery:
  - The pair loads `left_o`/`right_o` and sets `valid_o`.
  - `ack_i`=1 while `valid_o`=1 clears `valid_o` on the next clock.
  - New pair while `valid_o`=1 and `ack_i`=0: outputs are overwritten, `valid_o` stays 1, `overrun_o` is set.
  - New pair in the same cycle as an ack: the new pair loads, `valid_o` stays 1, no overrun.
- Reset values: `left_o`=0, `right_o`=0, `valid_o`=0, `overrun_o`=0, `frame_err_o`=0. Reset also sets FSM=HUNT, `have_left`=0, `bit_cnt`=0 and clears the synchronizers.
- Reset mid-frame: all partial data is lost. The first pair after reset requires a boundary followed by a full left slot and a full right slot.

## Timing
- The synchronizer plus edge detect adds 3 `clk` of latency from a BCK pin rising edge to `bck_rise`.
- `valid_o` rises on the `clk` edge after the `bck_rise` that shifts in the right word's WIDTH-th bit. That is at most 4 `clk` after the corresponding BCK pin edge.
- BCK high and low phases must each be ≥2 `clk`. DIN and LCK must be stable from 1 `clk` before to 2 `clk` after the BCK rising pin edge.
- Supported target: 44.1 kHz × 32 BCK per frame (1.4112 MHz), 16-bit slots. Slots longer than WIDTH (e.g. 64 BCK/frame) are supported through WAIT.

## Configuration
- `I2S_INPUT_FRAME_CHECK_EN` defined: `frame_err_o` is set, sticky until reset, whenever a boundary edge arrives in SHIFT (slot shorter than WIDTH). This includes the first boundary after HUNT only if that boundary ends a SHIFT.
- Undefined: the check logic is omitted and `frame_err_o` is tied 0. Short words are still discarded silently.

## Test plan
- Reset: assert `sys_rst_i` 2 cycles while inputs toggle -> all outputs 0; FSM in HUNT; no `valid_o` for a partial first frame.
- Basic frame: 32 BCK/frame, BCK = `clk`/4, left 16'h1234, right 16'hABCD -> `valid_o`=1 with `left_o`=1234, `right_o`=ABCD within 4 `clk` of the right LSB edge. Pulse `ack_i` -> `valid_o`=0 next cycle.
- Long slots: 64 BCK/frame, left 16'h8001 followed by 16 junk ones, right 16'h7FFE -> pair 8001/7FFE; junk bits ignored; `frame_err_o`=0.
- Overrun: two frames (1111/2222, then 3333/4444) with no ack -> outputs 3333/4444, `valid_o`=1, `overrun_o`=1. An ack coincident with a third pair -> no change to `overrun_o`, `valid_o` stays 1.
- Mid-frame start: release reset during a right slot -> that right word is dropped; the first `valid_o` carries the next full left+right pair.
- With `I2S_INPUT_FRAME_CHECK_EN`: a 12-bit left slot followed by a normal right slot -> `frame_err_o`=1 and no `valid_o` for that frame. The following good frame delivers normally.
